// File: rtl/vga_framebuffer_arbiter.sv
// Single-port framebuffer arbiter: VGA word prefetch has strict priority over a
// host read/write port; produces a registered 1 bpp pixel stream for 640x480.
module vga_framebuffer_arbiter #(
    parameter int ADDR_WIDTH     = 15,
    parameter int WORDS_PER_LINE = 40
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    input  logic                  blank,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [15:0]           host_wdata,
    output logic                  host_ack,
    output logic [15:0]           host_rdata,
    output logic                  pixel
);

    typedef enum logic [1:0] {
        H_IDLE,
        H_ISSUED,
        H_ACK
    } host_state_e;

    host_state_e           host_state, host_state_nxt;
    logic                  host_grant;
    logic                  host_ack_nxt;

    logic [9:0]            x_d;
    logic                  new_px;
    logic [15:0]           cur_word;
    logic [15:0]           prefetch;
    logic                  vid_pending;
    logic                  vid_inflight;
    logic [ADDR_WIDTH-1:0] vid_addr;

    logic [9:0]            word_idx;
    logic [9:0]            nl;
    logic                  word_adv;
    logic                  intra_fetch;
    logic                  nl_fetch;
    logic [ADDR_WIDTH-1:0] intra_addr;
    logic [ADDR_WIDTH-1:0] nl_addr;

    // Row base address; 40 words/line reduces to two shifts and an add.
    function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [9:0] row);
        logic [ADDR_WIDTH-1:0] r;
        r = ADDR_WIDTH'(row);
        if (WORDS_PER_LINE == 40)
            return (r << 5) + (r << 3);
        else
            return r * ADDR_WIDTH'(WORDS_PER_LINE);
    endfunction

    assign new_px   = (x != x_d);
    assign word_idx = {4'd0, x[9:4]};
    assign nl       = (y == 10'd524) ? 10'd0 : y + 10'd1;

    assign word_adv    = new_px && (x[3:0] == 4'd0) && (x < 10'd640) && (y < 10'd480);
    assign intra_fetch = word_adv && (word_idx < 10'(WORDS_PER_LINE - 1));
    assign nl_fetch    = new_px && (x == 10'd784) && (nl < 10'd480);
    assign intra_addr  = line_base(y) + ADDR_WIDTH'(word_idx) + ADDR_WIDTH'(1);
    assign nl_addr     = line_base(nl);

    // Host may only take the slot when no video fetch is waiting for it.
    assign host_grant = host_req && (host_state == H_IDLE) && !vid_pending;

    always_comb begin
        host_state_nxt = host_state;
        host_ack_nxt   = 1'b0;
        case (host_state)
            H_IDLE:   if (host_grant) host_state_nxt = H_ISSUED;
            H_ISSUED: begin
                host_state_nxt = H_ACK;
                host_ack_nxt   = 1'b1;
            end
            H_ACK:    host_state_nxt = H_IDLE;
            default:  host_state_nxt = H_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            host_state <= H_IDLE;
            host_ack   <= 1'b0;
            host_rdata <= 16'd0;
        end else begin
            host_state <= host_state_nxt;
            host_ack   <= host_ack_nxt;
            if (host_state == H_ISSUED && !host_we)
                host_rdata <= mem_rdata;
        end
    end

    // Fetch requests live for one cycle only: video always wins the next slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_d         <= 10'd0;
            vid_pending <= 1'b0;
            vid_addr    <= '0;
            cur_word    <= 16'd0;
        end else begin
            x_d         <= x;
            vid_pending <= intra_fetch || nl_fetch;
            if (intra_fetch)
                vid_addr <= intra_addr;
            else if (nl_fetch)
                vid_addr <= nl_addr;
            if (word_adv)
                cur_word <= prefetch;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_wdata    <= 16'd0;
            vid_inflight <= 1'b0;
            prefetch     <= 16'd0;
        end else begin
            vid_inflight <= 1'b0;
            if (vid_pending) begin
                mem_addr     <= vid_addr;
                mem_we       <= 1'b0;
                vid_inflight <= 1'b1;
            end else if (host_grant) begin
                mem_addr  <= host_addr;
                mem_we    <= host_we;
                mem_wdata <= host_wdata;
            end else begin
                mem_we <= 1'b0;
            end
            if (vid_inflight)
                prefetch <= mem_rdata;
        end
    end

    // Column 0 of a word comes straight from prefetch, since cur_word loads on that edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pixel <= 1'b0;
        else if (blank)
            pixel <= 1'b0;
        else if (x[3:0] == 4'd0)
            pixel <= prefetch[15];
        else
            pixel <= cur_word[4'd15 - x[3:0]];
    end

endmodule

// File: tb/tb_vga_framebuffer_arbiter.sv
// Directed bench for vga_framebuffer_arbiter: drives pixel coordinates directly,
// models the RAM, and checks fetch addresses, pixels and host handshakes.
module tb_vga_framebuffer_arbiter;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [9:0]    x, y;
    logic          blank;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [15:0]   mem_wdata, mem_rdata;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [15:0]   host_wdata, host_rdata;
    logic          host_ack, pixel;

    logic [15:0]   ram [0:(1<<AW)-1];
    int            n_chk = 0;
    int            n_err = 0;
    int            pend = -1;
    int            last_fetch = 0;

    always #5 clk = ~clk;

    // RAM: data for the registered address is visible one clk after it was issued.
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) if (mem_we) ram[mem_addr] = mem_wdata;

    vga_framebuffer_arbiter #(.ADDR_WIDTH(AW), .WORDS_PER_LINE(40)) dut (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .blank(blank),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata), .pixel(pixel)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input int a);
        if (a == 40) return 16'h8001;
        return 16'(a);
    endfunction

    function automatic logic exp_px(input int xx, input int yy);
        logic [15:0] w;
        if (xx >= 640 || yy >= 480) return 1'b0;
        w = exp_word(yy * 40 + xx / 16);
        return w[15 - (xx % 16)];
    endfunction

    function automatic int exp_fetch(input int xx, input int yy);
        int nl;
        if (xx < 640 && yy < 480 && xx % 16 == 0 && xx / 16 < 39) return yy * 40 + xx / 16 + 1;
        if (xx == 784) begin
            nl = (yy == 524) ? 0 : yy + 1;
            if (nl < 480) return nl * 40;
        end
        return -1;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_addr"},  32'(mem_addr),   0);
        chk({tag, "_we"},    32'(mem_we),     0);
        chk({tag, "_wdata"}, 32'(mem_wdata),  0);
        chk({tag, "_ack"},   32'(host_ack),   0);
        chk({tag, "_rdata"}, 32'(host_rdata), 0);
        chk({tag, "_pixel"}, 32'(pixel),      0);
    endtask

    // One pixel step: x held for two clocks; previous step's fetch shows up first.
    task automatic tick(input int nx, input int ny, input bit px_en, input bit quiet);
        @(posedge clk); #1;
        x = 10'(nx);
        y = 10'(ny);
        blank = (nx >= 640 || ny >= 480);
        @(negedge clk);
        if (pend >= 0) begin
            chk($sformatf("fetch_addr x%0d y%0d", nx, ny), 32'(mem_addr), pend);
            chk($sformatf("fetch_we x%0d y%0d", nx, ny), 32'(mem_we), 0);
            last_fetch = pend;
        end else if (quiet) begin
            chk($sformatf("no_fetch x%0d y%0d", nx, ny), 32'(mem_addr), last_fetch);
        end
        @(negedge clk);
        if (px_en || blank)
            chk($sformatf("pixel x%0d y%0d", nx, ny), 32'(pixel), 32'(exp_px(nx, ny)));
        pend = exp_fetch(nx, ny);
    endtask

    task automatic sweep(input int ny, input int xa, input int xb, input bit px_en, input bit quiet);
        for (int i = xa; i <= xb; i++) tick(i, ny, px_en, quiet);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int  lat;
        bit  seen;
        reset_n = 1'b1;
        x = 10'd0; y = 10'd0; blank = 1'b1;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = 16'd0;
        for (int i = 0; i < (1 << AW); i++) ram[i] = 16'(i);
        ram[40] = 16'h8001;

        // Reset
        #2 reset_n = 1'b0;
        #1 check_zero("rst_async");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("rst_hold");
        reset_n = 1'b1;
        @(negedge clk);
        check_zero("rst_rel");

        // Line 5: fetches 201..239, none at x=624, next-line 240 at x=784
        sweep(4, 780, 799, 1'b0, 1'b1);
        sweep(5, 0, 625, 1'b1, 1'b1);
        chk("x624_nofetch", 32'(mem_addr), 239);
        sweep(5, 626, 799, 1'b1, 1'b1);
        chk("l5_nl_fetch", 32'(last_fetch), 240);

        // Line 1 shows word 40 = 8001, then blanked columns
        sweep(0, 784, 799, 1'b0, 1'b1);
        sweep(1, 0, 31, 1'b1, 1'b1);
        sweep(1, 640, 660, 1'b0, 1'b1);

        // Frame wrap and last-line boundary
        tick(783, 524, 1'b0, 1'b1);
        tick(784, 524, 1'b0, 1'b1);
        tick(785, 524, 1'b0, 1'b1);
        chk("y524_fetch0", 32'(mem_addr), 0);
        tick(783, 479, 1'b0, 1'b1);
        tick(784, 479, 1'b0, 1'b1);
        tick(785, 479, 1'b0, 1'b1);
        chk("y479_nofetch", 32'(mem_addr), 0);

        // Host write/read traffic concurrent with a live line
        fork
            begin
                sweep(5, 784, 799, 1'b0, 1'b0);
                sweep(6, 0, 799, 1'b1, 1'b0);
            end
            begin
                @(posedge clk); #1;
                for (int i = 0; i < 6; i++) begin
                    host_req = 1'b1;
                    host_we = (i % 2 == 0);
                    host_addr = 15'd100;
                    host_wdata = 16'hA5C3;
                    lat = 0;
                    seen = 1'b0;
                    for (int k = 0; k < 6 && !seen; k++) begin
                        @(negedge clk);
                        if (host_ack) seen = 1'b1;
                        else lat++;
                    end
                    chk($sformatf("h_ack_seen %0d", i), 32'(seen), 1);
                    chk($sformatf("h_lat %0d", i), 32'(lat == 2 || lat == 3), 1);
                    if (i % 2 == 1) chk($sformatf("h_rdata %0d", i), 32'(host_rdata), 32'h0000A5C3);
                    @(posedge clk); #1;
                end
                host_req = 1'b0;
                @(negedge clk);
                chk("h_ack_end", 32'(host_ack), 0);
            end
        join

        // Host request arrives while a video fetch is pending
        @(posedge clk); #1;
        x = 10'd32; y = 10'd7; blank = 1'b0;
        @(posedge clk); #1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 15'd300;
        @(negedge clk);
        @(negedge clk);
        chk("sim_vid_addr", 32'(mem_addr), 283);
        chk("sim_vid_ack", 32'(host_ack), 0);
        @(negedge clk);
        chk("sim_host_addr", 32'(mem_addr), 300);
        chk("sim_host_we", 32'(mem_we), 0);
        chk("sim_host_ack0", 32'(host_ack), 0);
        @(negedge clk);
        chk("sim_ack", 32'(host_ack), 1);
        chk("sim_rdata", 32'(host_rdata), 32'h0000012C);
        @(posedge clk); #1;
        host_req = 1'b0;
        @(negedge clk);
        chk("sim_ack_off", 32'(host_ack), 0);

        // Reset while a host write is issued
        @(posedge clk); #1;
        x = 10'd700; y = 10'd10; blank = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        host_req = 1'b1; host_we = 1'b1; host_addr = 15'd500; host_wdata = 16'h1234;
        @(negedge clk);
        @(negedge clk);
        chk("g_iss_addr", 32'(mem_addr), 500);
        chk("g_iss_we", 32'(mem_we), 1);
        #1 reset_n = 1'b0; host_req = 1'b0;
        #1 check_zero("g_rst");
        repeat (3) begin
            @(negedge clk);
            chk("g_rst_ack", 32'(host_ack), 0);
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_zero("g_post");
        end
        @(posedge clk); #1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 15'd100;
        @(negedge clk);
        chk("g_re_ack0", 32'(host_ack), 0);
        @(negedge clk);
        chk("g_re_addr", 32'(mem_addr), 100);
        chk("g_re_ack1", 32'(host_ack), 0);
        @(negedge clk);
        chk("g_re_ack", 32'(host_ack), 1);
        chk("g_re_rdata", 32'(host_rdata), 32'h0000A5C3);
        @(posedge clk); #1;
        host_req = 1'b0;
        @(negedge clk);
        chk("g_re_ack_off", 32'(host_ack), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vga_framebuffer_arbiter.md
Name: vga_framebuffer_arbiter

Overview:
- Shares one single-port framebuffer RAM between the VGA scan-out path and a host port.
- Input: pixel coordinates and blank from the VGA timing generator, which advances x once every 2 clk cycles.
- Per access cycle, video prefetch has strict priority; the host gets every remaining cycle.
- Output: registered 1 bpp pixel stream, 640x480, 16 pixels per memory word, 40 words per line.

Parameters:
- ADDR_WIDTH, 15, framebuffer word-address width (19200 words used).
- WORDS_PER_LINE, 40, memory words per visible line.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- x  in  10  current pixel column from timing generator (0..799)
- y  in  10  current line from timing generator (0..524)
- blank  in  1  high outside 640x480 visible area
- mem_addr  out  ADDR_WIDTH  RAM word address
- mem_we  out  1  RAM write enable
- mem_wdata  out  16  RAM write data
- mem_rdata  in  16  RAM read data, valid exactly 1 clk after address
- host_req  in  1  host access request, held until host_ack
- host_we  in  1  1 = write, 0 = read; stable while host_req is high
- host_addr  in  ADDR_WIDTH  host word address; stable while host_req is high
- host_wdata  in  16  host write data; stable while host_req is high
- host_ack  out  1  one-cycle pulse, 1 clk after the host access is issued
- host_rdata  out  16  read data, valid while host_ack is high
- pixel  out  1  pixel value, 1 clk behind x

Behaviour:
- Reset (async, reset_n=0) clears: mem_we, mem_addr, mem_wdata, host_ack, host_rdata, pixel, cur_word, prefetch, x_d, vid_pending, vid_inflight, host FSM.
  - An outstanding host access is dropped without ack; the host must re-request.
- Pixel-edge detect: x_d <= x every cycle; new_px = (x != x_d).
- Fetch triggers, each evaluated on a new_px cycle:
  - Word advance: x[3:0]==0 && x<640 && y<480 → cur_word <= prefetch. If x>>4 < 39, set vid_pending with vid_addr = y*40 + (x>>4) + 1.
  - Next-line prefetch: x==784 → nl = (y==524) ? 0 : y+1. If nl<480, set vid_pending with vid_addr = nl*40.
  - Address multiply: y*40 = (y<<5)+(y<<3), computed to ADDR_WIDTH bits; maximum address 19199.
- Memory slot, each cycle, highest priority first:
  1. vid_pending: mem_addr <= vid_addr, mem_we <= 0; clear vid_pending, set vid_inflight. Next cycle, prefetch <= mem_rdata.
  2. Else, host FSM in IDLE with host_req=1: mem_addr <= host_addr, mem_we <= host_we, mem_wdata <= host_wdata; go to ISSUED.
  3. Else: mem_we <= 0.
- Host FSM:
  - IDLE → ISSUED on grant.
  - ISSUED → ACK: host_ack=1 for exactly one cycle; for a read, host_rdata <= mem_rdata.
  - ACK → IDLE next cycle, so the host may issue back-to-back requests.
  - A host access is never preempted once issued.
  - Worst-case grant wait is 1 cycle, since video needs only 1 slot per 32 clk.
- Simultaneous requests: when video and host request in the same cycle, video wins and host is issued the following cycle.
- Pixel output, registered every cycle:
  - pixel <= 0 if blank.
  - Else pixel <= (x[3:0]==0 ? prefetch[15] : cur_word[15 - x[3:0]]); MSB is the leftmost pixel.
- First frame after reset: line 0 word 0 was not prefetched, so that word shows prefetch reset value 0. All later frames are correct.
- Host writes to the word being displayed take effect on the next fetch of that word; no tearing protection.

Test Plan:
- Reset then free-run the timing generator for 2 frames, RAM preloaded with word n = n → on line 5, mem_addr fetches are 201..239 at x=0,16,..,608 edges and 240 at x=784. Each fetch's prefetch value equals its address.
- RAM word 40 = 16'h8001, displayed line 1 → pixel=1 exactly at x=0 and x=15 of that line (1 clk after x change), 0 elsewhere; pixel=0 throughout blank.
- host_req held continuously, alternating write/read to addr 100 with data 16'hA5C3 → each host_ack is one cycle wide and occurs 2 clk after grant. Readback is 16'hA5C3. No video fetch is missed: every prefetch updates before its x[3:0]==0 edge.
- host_req rises in the same cycle vid_pending is set → video address on mem_addr that cycle, host address the next cycle, host_ack one cycle later.
- reset_n pulsed low while host FSM is ISSUED → host_ack never asserts; after release, all outputs are 0 and a fresh host request completes normally.
- y=524, x=784 → vid_addr=0 fetched. y=479, x=784 → no fetch (nl=480). x=624 → no intra-line fetch (word 39 is last).
